// File: rtl/ap_ctrl_chain_driver.sv
// Initiator for the HLS block-level ap_ctrl_chain handshake.
// Accepts a run command (transaction count + continue-stall length), issues that many
// starts to one HLS block via ap_start while bounding in-flight work, completes each
// transaction via ap_continue (optionally held low for a stall window after every done),
// then pulses finish for one cycle.
// Ports:
//   clk_i, rst_i        clock (rising edge) and synchronous active-high reset
//   cmd_valid_i/ready_o run request handshake; cmd_num_i, cmd_stall_i sampled on it
//   ap_start_o, ap_ready_i, ap_done_i, ap_continue_o   block-level handshake to the HLS block
//   busy_o, finish_o    run in progress / one-cycle completion pulse
//   start_cnt_o, done_cnt_o, first_lat_o, total_cyc_o  per-run statistics (saturating)
//   proto_err_o         sticky: done accepted while nothing was outstanding
module ap_ctrl_chain_driver #(
  parameter int unsigned COUNT_W         = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STALL_W         = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [COUNT_W-1:0] cmd_num_i,
  input  logic [STALL_W-1:0] cmd_stall_i,
  output logic               ap_start_o,
  input  logic               ap_ready_i,
  input  logic               ap_done_i,
  output logic               ap_continue_o,
  output logic               busy_o,
  output logic               finish_o,
  output logic [COUNT_W-1:0] start_cnt_o,
  output logic [COUNT_W-1:0] done_cnt_o,
  output logic [COUNT_W-1:0] first_lat_o,
  output logic [COUNT_W-1:0] total_cyc_o,
  output logic               proto_err_o
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OutW-1:0]    MaxOut = OutW'(MAX_OUTSTANDING);
  localparam logic [COUNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFinish} state_e;

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] num_q, num_d;
  logic [STALL_W-1:0] stall_len_q, stall_len_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [OutW-1:0]    out_q, out_d;
  logic [COUNT_W-1:0] start_cnt_q, start_cnt_d;
  logic [COUNT_W-1:0] done_cnt_q, done_cnt_d;
  logic [COUNT_W-1:0] first_lat_q, first_lat_d;
  logic [COUNT_W-1:0] total_cyc_q, total_cyc_d;
  logic               proto_err_q, proto_err_d;
  logic               seen_start_q, seen_start_d;
  logic               seen_done_q, seen_done_d;
  logic               ap_start_q, ap_start_d;
  logic               ap_continue_q, ap_continue_d;

  logic active, start_hs, done_hs, done_ok;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == CntMax) ? v : v + COUNT_W'(1);
  endfunction

  always_comb begin
    state_d       = state_q;
    num_d         = num_q;
    stall_len_d   = stall_len_q;
    stall_cnt_d   = stall_cnt_q;
    out_d         = out_q;
    start_cnt_d   = start_cnt_q;
    done_cnt_d    = done_cnt_q;
    first_lat_d   = first_lat_q;
    total_cyc_d   = total_cyc_q;
    proto_err_d   = proto_err_q;
    seen_start_d  = seen_start_q;
    seen_done_d   = seen_done_q;
    done_ok       = 1'b0;
    active        = (state_q == StRun) || (state_q == StDrain);
    start_hs      = ap_start_q && ap_ready_i;
    done_hs       = active && ap_done_i && ap_continue_q;

    if (stall_cnt_q != '0) stall_cnt_d = stall_cnt_q - STALL_W'(1);

    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          num_d        = cmd_num_i;
          stall_len_d  = cmd_stall_i;
          stall_cnt_d  = '0;
          out_d        = '0;
          start_cnt_d  = '0;
          done_cnt_d   = '0;
          first_lat_d  = '0;
          total_cyc_d  = '0;
          proto_err_d  = 1'b0;
          seen_start_d = 1'b0;
          seen_done_d  = 1'b0;
          state_d      = (cmd_num_i == '0) ? StFinish : StRun;
        end
      end
      StRun, StDrain: begin
        total_cyc_d = sat_inc(total_cyc_q);
        // Latency window opens at the first start edge and closes at the first done edge.
        if (seen_start_q && !seen_done_q) first_lat_d = sat_inc(first_lat_q);
        if (start_hs) begin
          start_cnt_d  = sat_inc(start_cnt_q);
          seen_start_d = 1'b1;
        end
        if (done_hs) begin
          if (out_q == '0) begin
            proto_err_d = 1'b1;
          end else begin
            done_ok     = 1'b1;
            done_cnt_d  = sat_inc(done_cnt_q);
            seen_done_d = 1'b1;
            stall_cnt_d = stall_len_q;
          end
        end
        if (start_hs && !done_ok) begin
          out_d = out_q + OutW'(1);
        end else if (!start_hs && done_ok) begin
          out_d = out_q - OutW'(1);
        end
        if ((state_q == StRun) && (start_cnt_d == num_q)) begin
          state_d = StDrain;
        end else if ((state_q == StDrain) && (done_cnt_d == num_q)) begin
          state_d = StFinish;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Both handshake outputs are registered and derived from the post-edge view.
    ap_start_d    = (state_d == StRun) && (start_cnt_d < num_d) && (out_d < MaxOut);
    ap_continue_d = ((state_d == StRun) || (state_d == StDrain)) && (stall_cnt_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      num_q         <= '0;
      stall_len_q   <= '0;
      stall_cnt_q   <= '0;
      out_q         <= '0;
      start_cnt_q   <= '0;
      done_cnt_q    <= '0;
      first_lat_q   <= '0;
      total_cyc_q   <= '0;
      proto_err_q   <= 1'b0;
      seen_start_q  <= 1'b0;
      seen_done_q   <= 1'b0;
      ap_start_q    <= 1'b0;
      ap_continue_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_q         <= num_d;
      stall_len_q   <= stall_len_d;
      stall_cnt_q   <= stall_cnt_d;
      out_q         <= out_d;
      start_cnt_q   <= start_cnt_d;
      done_cnt_q    <= done_cnt_d;
      first_lat_q   <= first_lat_d;
      total_cyc_q   <= total_cyc_d;
      proto_err_q   <= proto_err_d;
      seen_start_q  <= seen_start_d;
      seen_done_q   <= seen_done_d;
      ap_start_q    <= ap_start_d;
      ap_continue_q <= ap_continue_d;
    end
  end

  assign cmd_ready_o   = (state_q == StIdle);
  assign busy_o        = (state_q == StRun) || (state_q == StDrain);
  assign finish_o      = (state_q == StFinish);
  assign ap_start_o    = ap_start_q;
  assign ap_continue_o = ap_continue_q;
  assign start_cnt_o   = start_cnt_q;
  assign done_cnt_o    = done_cnt_q;
  assign first_lat_o   = first_lat_q;
  assign total_cyc_o   = total_cyc_q;
  assign proto_err_o   = proto_err_q;

endmodule

// File: tb/tb_ap_ctrl_chain_driver.sv
// Bench for ap_ctrl_chain_driver: a transaction-level reference model (counts, edge
// timestamps, FIFO of start times) predicts every output each cycle; a fake HLS block
// answers ap_start/ap_continue with randomized ready/done timing.
module tb_ap_ctrl_chain_driver;
  localparam int CW = 32;
  localparam int MO = 2;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [CW-1:0] cmd_num = '0;
  logic [SW-1:0] cmd_stall = '0;
  logic          ap_ready = 1'b0;
  logic          ap_done = 1'b0;
  logic          cmd_ready, ap_start, ap_continue, busy, finish, proto_err;
  logic [CW-1:0] start_cnt, done_cnt, first_lat, total_cyc;

  always #5 clk = ~clk;

  ap_ctrl_chain_driver #(.COUNT_W(CW), .MAX_OUTSTANDING(MO), .STALL_W(SW)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_num_i(cmd_num), .cmd_stall_i(cmd_stall), .ap_start_o(ap_start),
    .ap_ready_i(ap_ready), .ap_done_i(ap_done), .ap_continue_o(ap_continue),
    .busy_o(busy), .finish_o(finish), .start_cnt_o(start_cnt), .done_cnt_o(done_cnt),
    .first_lat_o(first_lat), .total_cyc_o(total_cyc), .proto_err_o(proto_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model. Phase: 0 idle, 1 issuing, 2 draining, 3 finishing.
  int     m_phase = 0;
  int     m_edge = 0;
  longint m_num = 0;
  int     m_stall = 0;
  int     m_starts = 0, m_dones = 0, m_cmd_edge = 0;
  int     m_fs = -1, m_fd = -1, m_ld = -1, m_total = 0;
  bit     m_proto = 0, m_init = 0;
  int     q_start[$];

  function automatic bit e_busy();
    return (m_phase == 1) || (m_phase == 2);
  endfunction
  function automatic bit e_start();
    return (m_phase == 1) && (m_starts < m_num) && ((m_starts - m_dones) < MO);
  endfunction
  function automatic bit e_cont();
    return e_busy() && ((m_ld < 0) || (m_edge - m_ld >= m_stall));
  endfunction
  function automatic int e_total();
    return e_busy() ? (m_edge - m_cmd_edge) : m_total;
  endfunction
  function automatic int e_flat();
    if (m_fs < 0) return 0;
    return (m_fd < 0) ? (m_edge - m_fs) : (m_fd - m_fs);
  endfunction

  initial forever begin
    bit sh, dh;
    @(posedge clk);
    sh = e_start() && ap_ready;
    dh = e_cont() && ap_done;
    m_edge++;
    if (rst) begin
      m_phase = 0; m_starts = 0; m_dones = 0; m_fs = -1; m_fd = -1; m_ld = -1;
      m_total = 0; m_proto = 0; m_num = 0; m_stall = 0; m_cmd_edge = 0;
      q_start.delete();
      m_init = 1;
    end else begin
      case (m_phase)
        0: if (cmd_valid) begin
          m_num = longint'(cmd_num); m_stall = int'(cmd_stall);
          m_starts = 0; m_dones = 0; m_fs = -1; m_fd = -1; m_ld = -1;
          m_total = 0; m_proto = 0; m_cmd_edge = m_edge;
          q_start.delete();
          m_phase = (m_num == 0) ? 3 : 1;
        end
        1, 2: begin
          if (dh) begin
            if (m_starts == m_dones) m_proto = 1;
            else begin
              m_dones++; m_ld = m_edge;
              if (m_fd < 0) m_fd = m_edge;
              void'(q_start.pop_front());
            end
          end
          if (sh) begin
            m_starts++;
            if (m_fs < 0) m_fs = m_edge;
            q_start.push_back(m_edge);
          end
          if (m_phase == 1 && m_starts == m_num) m_phase = 2;
          else if (m_phase == 2 && m_dones == m_num) begin
            m_phase = 3; m_total = m_edge - m_cmd_edge;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle comparison and event tallies (DUT-observed).
  int cnt_fin = 0, cnt_lowcont = 0, cnt_start0 = 0, cnt_starthi = 0;
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      chk("cmd_ready", longint'(cmd_ready), longint'(m_phase == 0));
      chk("busy", longint'(busy), longint'(e_busy()));
      chk("finish", longint'(finish), longint'(m_phase == 3));
      chk("ap_start", longint'(ap_start), longint'(e_start()));
      chk("ap_continue", longint'(ap_continue), longint'(e_cont()));
      chk("start_cnt", longint'(start_cnt), longint'(m_starts));
      chk("done_cnt", longint'(done_cnt), longint'(m_dones));
      chk("first_lat", longint'(first_lat), longint'(e_flat()));
      chk("total_cyc", longint'(total_cyc), longint'(e_total()));
      chk("proto_err", longint'(proto_err), longint'(m_proto));
      if (finish) cnt_fin++;
      if (busy && !ap_continue) cnt_lowcont++;
      if (ap_start && start_cnt == '0) cnt_start0++;
      if (ap_start) cnt_starthi++;
    end
  end

  // Fake HLS block: each transaction may complete lat edges after its start; ap_done is
  // held once raised until the handshake consumes it.
  int unsigned ready_pct = 100, done_pct = 100;
  int lat = 1, ready_hold = 0;
  bit spur_arm = 0;
  initial forever begin
    @(negedge clk);
    if (ready_hold > 0) begin
      ap_ready = 1'b0;
      if (e_start()) ready_hold--;
    end else begin
      ap_ready = ($urandom_range(99) < ready_pct);
    end
    if (spur_arm && m_phase == 1) begin
      ap_done = 1'b1;
      spur_arm = 0;
    end else if (q_start.size() > 0 && m_edge >= q_start[0] + lat - 1) begin
      if (!ap_done) ap_done = ($urandom_range(99) < done_pct);
    end else begin
      ap_done = 1'b0;
    end
  end

  int b_fin, b_lowcont, b_start0, b_starthi;

  task automatic wait_idle();
    int g = 0;
    while (m_phase != 0) begin
      if (g >= 3000) begin
        n_chk++; n_err++;
        $display("FAIL idle_timeout: got phase %0d, want 0", m_phase);
        break;
      end
      @(negedge clk);
      g++;
    end
  endtask

  task automatic issue(input longint num, input int stall);
    wait_idle();
    @(negedge clk);
    b_fin = cnt_fin; b_lowcont = cnt_lowcont; b_start0 = cnt_start0; b_starthi = cnt_starthi;
    cmd_valid = 1'b1; cmd_num = CW'(num); cmd_stall = SW'(stall);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input longint num, input int stall, input int unsigned rp,
                         input int unsigned dp, input int lt, input bit noise);
    int g = 0;
    ready_pct = rp; done_pct = dp; lat = lt;
    issue(num, stall);
    while (m_phase != 0) begin
      if (g >= 3000) begin
        n_chk++; n_err++;
        $display("FAIL run_timeout: got phase %0d, want 0", m_phase);
        break;
      end
      // Commands offered while busy must be ignored.
      cmd_valid = noise ? 1'($urandom_range(1)) : 1'b0;
      cmd_num = CW'($urandom_range(7));
      cmd_stall = SW'($urandom_range(7));
      @(negedge clk);
      g++;
    end
    cmd_valid = 1'b0;
    chk("finish_pulses", longint'(cnt_fin - b_fin), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_cmd_ready", longint'(cmd_ready), 1);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_ap_start", longint'(ap_start), 0);
    chk("rst_ap_continue", longint'(ap_continue), 0);
    chk("rst_total_cyc", longint'(total_cyc), 0);

    // Zero-length run.
    run_cmd(0, 0, 100, 100, 1, 0);
    chk("n0_start_hi", longint'(cnt_starthi - b_starthi), 0);
    chk("n0_total_cyc", longint'(total_cyc), 0);
    chk("n0_start_cnt", longint'(start_cnt), 0);

    // Four transactions, latency 3, no stall.
    run_cmd(4, 0, 100, 100, 3, 0);
    chk("n4_start_cnt", longint'(start_cnt), 4);
    chk("n4_done_cnt", longint'(done_cnt), 4);
    chk("n4_first_lat", longint'(first_lat), 3);
    chk("n4_total_cyc", longint'(total_cyc), 9);

    // Continue stall of 5 after each done.
    run_cmd(3, 5, 100, 100, 1, 0);
    chk("st_done_cnt", longint'(done_cnt), 3);
    chk("st_lowcont", longint'(cnt_lowcont - b_lowcont), 10);
    chk("st_total_cyc", longint'(total_cyc), 14);

    // ap_ready withheld for the first 10 cycles of ap_start.
    ready_hold = 10;
    run_cmd(2, 0, 100, 100, 2, 0);
    chk("rh_start0", longint'(cnt_start0 - b_start0), 11);
    chk("rh_start_cnt", longint'(start_cnt), 2);

    // Spurious done with nothing outstanding.
    ready_hold = 3;
    spur_arm = 1;
    run_cmd(1, 0, 100, 100, 1, 0);
    chk("sp_proto_err", longint'(proto_err), 1);
    chk("sp_done_cnt", longint'(done_cnt), 1);
    run_cmd(0, 0, 100, 100, 1, 0);
    chk("sp_proto_clr", longint'(proto_err), 0);

    // Reset while draining with one transaction in flight.
    ready_pct = 100; done_pct = 100; lat = 20;
    issue(1, 0);
    for (int g = 0; g < 50 && m_phase != 2; g++) @(negedge clk);
    chk("rs_in_drain", longint'(m_phase), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rs_cmd_ready", longint'(cmd_ready), 1);
    chk("rs_start_cnt", longint'(start_cnt), 0);
    repeat (5) @(negedge clk);
    chk("rs_no_finish", longint'(cnt_fin - b_fin), 0);
    run_cmd(1, 0, 100, 100, 2, 0);
    chk("rs_rerun_done", longint'(done_cnt), 1);

    // Randomized runs with command noise while busy.
    for (int i = 0; i < 25; i++) begin
      run_cmd(longint'($urandom_range(6)), int'($urandom_range(4)), $urandom_range(100, 20),
              $urandom_range(100, 30), int'($urandom_range(5, 1)), 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_chain_driver.md
# ap_ctrl_chain_driver

Synthesizable initiator for the HLS block-level ap_ctrl_chain handshake. It issues a commanded number of transactions to one DUT by driving ap_start/ap_continue, obeys ap_ready/ap_done, and can inject ap_continue back-pressure. It emits a one-cycle `finish` pulse plus latency/throughput counters for the dataflow status monitors and the top-level bench sequencer.

## Interface
- COUNT_W, 32: width of transaction-count and cycle counters.
- MAX_OUTSTANDING, 2: maximum started-but-not-done transactions (≥1).
- STALL_W, 8: width of the continue-stall length.

- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  run request.
- cmd_ready  out  1  high only in IDLE.
- cmd_num  in  COUNT_W  transactions to issue, sampled on cmd handshake.
- cmd_stall  in  STALL_W  ap_continue low cycles after each done, sampled on cmd handshake.
- ap_start  out  1  to DUT.
- ap_ready  in  1  from DUT.
- ap_done  in  1  from DUT.
- ap_continue  out  1  to DUT.
- busy  out  1  state is RUN or DRAIN.
- finish  out  1  one-cycle pulse when the run completes.
- start_cnt  out  COUNT_W  accepted starts in the current run.
- done_cnt  out  COUNT_W  accepted dones in the current run.
- first_lat  out  COUNT_W  cycles from first start handshake to first done handshake.
- total_cyc  out  COUNT_W  cycles from cmd handshake to last done handshake.
- proto_err  out  1  sticky: ap_done accepted with zero outstanding.

## Operation
- States: IDLE, RUN, DRAIN, FINISH. Reset → IDLE.
- Reset values: all outputs 0 except cmd_ready=1. Counters, stall counter and outstanding are 0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch cmd_num and cmd_stall and clear all counters and proto_err.
  - If cmd_num=0, go to FINISH. Otherwise go to RUN.
- Start handshake is `ap_start && ap_ready` at a rising edge. It increments start_cnt and outstanding.
- Done handshake is `ap_done && ap_continue` at a rising edge, in RUN or DRAIN only. It increments done_cnt, decrements outstanding and loads the stall counter with cmd_stall.
- If both handshakes fall on the same edge, outstanding is unchanged and both counters increment.
- ap_start is registered. Next value = (next state RUN) && (next start_cnt < num) && (next outstanding < MAX_OUTSTANDING). Once asserted it is held until the handshake.
- ap_continue is registered.
  - Next value = (next state RUN or DRAIN) && (next stall counter = 0).
  - The stall counter decrements each cycle while nonzero.
  - ap_continue is 0 in IDLE and FINISH.
- RUN → DRAIN on the edge where start_cnt reaches num.
- DRAIN → FINISH on the edge where done_cnt reaches num.
- FINISH lasts exactly one cycle with finish=1, then returns to IDLE.
- Protocol error: a done handshake with outstanding=0 sets proto_err. It is not counted and outstanding does not underflow.
- Arithmetic:
  - Counters are unsigned and saturate at all-ones.
  - outstanding is a clog2(MAX_OUTSTANDING+1)-bit register.
  - Comparisons against cmd_num are full width.
- cmd_valid outside IDLE is ignored.

## Timing
- cmd handshake at edge T:
  - busy=1 and ap_start=1 from T+1.
  - total_cyc counts 1 at the first edge after T and advances every edge through the final done handshake, then freezes.
- first_lat: 0 at the first start handshake, +1 per edge until the first done handshake, then frozen.
- Minimum issue interval: one start per cycle while ap_ready is held high and the outstanding limit is not reached.
- A done handshake at edge D drives ap_continue=0 during cycles D+1..D+cmd_stall and 1 again from D+cmd_stall+1.
- Last done handshake at edge L:
  - state=FINISH and finish=1 during L+1.
  - IDLE and cmd_ready=1 from L+2.
- Reset asserted mid-run: on the next edge, all outputs take reset values and any in-flight transaction is abandoned. No finish pulse is generated.

## Test plan
- cmd_num=0 → finish pulses exactly one cycle after the cmd handshake, ap_start never asserted, all counters 0.
- cmd_num=4, stall=0, DUT ap_ready always 1, done 3 cycles after start, MAX_OUTSTANDING=2 → start_cnt=done_cnt=4, first_lat=3, ap_start never high when outstanding=2, single finish pulse.
- cmd_num=3, stall=5, DUT holds ap_done high until continue → each done held ≥5 cycles, ap_continue low exactly 5 cycles after each handshake, done_cnt=3.
- ap_ready held low 10 cycles after first ap_start → ap_start stays high all 10 cycles, start_cnt=0 until ready.
- Spurious ap_done pulse with outstanding=0 in RUN → proto_err=1 and done_cnt unchanged; proto_err clears on the next cmd handshake.
- Reset asserted in DRAIN with 1 outstanding → next cycle IDLE, cmd_ready=1, counters 0, no finish; a new cmd_num=1 run then completes normally.
